// File: rtl/pci_initiator_ctrl.sv
// PCI bus initiator: arbitrates with REQ#/GNT#, runs one address phase and 1..8
// burst data phases on the multiplexed AD bus, then reports done or master abort.
module pci_initiator_ctrl #(
  parameter int MAX_BURST      = 8,
  parameter int DEVSEL_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_n,
  input  logic        gnt_n,
  output logic        frame_n,
  output logic        irdy_n,
  input  logic        trdy_n,
  input  logic        devsel_n,
  inout  wire  [31:0] ad,
  output logic [3:0]  c_be,
  input  logic        start,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [2:0]  len,
  input  logic        wr_we,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        done,
  output logic        abort,
  output logic [2:0]  fsm_state
);

  localparam int PW = $clog2(MAX_BURST);
  localparam int RW = PW + 1;
  localparam int CW = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_TURN = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    cmd_q;
  logic [31:0]   addr_q;
  logic [RW-1:0] remaining;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] dev_cnt;
  logic          dev_seen;
  logic [31:0]   wbuf [MAX_BURST];

  logic        is_write, phase_ok, last_phase, timeout, ad_oe;
  logic [31:0] ad_out;

  // Request handshake: a start pulse is taken only while busy=0; busy then stays
  // high until the TURN cycle ends. Write-buffer pushes are taken only in IDLE.
  assign is_write   = cmd_q[0];
  assign last_phase = (remaining == RW'(1));
  assign phase_ok   = (state == S_DATA) && !trdy_n && !devsel_n;
  assign timeout    = (state == S_DATA) && !dev_seen && devsel_n &&
                      (dev_cnt == CW'(DEVSEL_TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_REQ;
      S_REQ:  if (!gnt_n) state_nx = S_ADDR;
      S_ADDR: state_nx = S_DATA;
      S_DATA: if (timeout || (phase_ok && last_phase)) state_nx = S_TURN;
      S_TURN: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_n   = 1'b1;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    c_be    = 4'b1111;
    ad_oe   = 1'b0;
    ad_out  = wbuf[rd_ptr];
    case (state)
      S_REQ: req_n = 1'b0;
      S_ADDR: begin
        frame_n = 1'b0;
        c_be    = cmd_q;
        ad_oe   = 1'b1;
        ad_out  = addr_q;
      end
      S_DATA: begin
        // FRAME# drops away during the final phase while IRDY# stays asserted.
        frame_n = last_phase;
        irdy_n  = 1'b0;
        c_be    = 4'b0000;
        ad_oe   = is_write;
      end
      default: ;
    endcase
  end

  assign ad        = ad_oe ? ad_out : 32'hzzzz_zzzz;
  assign busy      = (state != S_IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      remaining <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      dev_cnt   <= '0;
      dev_seen  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wr_we)
            wr_ptr <= (wr_ptr == PW'(MAX_BURST - 1)) ? '0 : wr_ptr + PW'(1);
          if (start) begin
            cmd_q     <= cmd;
            addr_q    <= addr;
            remaining <= RW'(len) + RW'(1);
            rd_ptr    <= '0;
          end
        end
        S_ADDR: begin
          dev_cnt  <= '0;
          dev_seen <= 1'b0;
        end
        S_DATA: begin
          if (!devsel_n)
            dev_seen <= 1'b1;
          else if (!dev_seen)
            dev_cnt <= dev_cnt + CW'(1);
          if (timeout) begin
            abort <= 1'b1;
          end else if (phase_ok) begin
            rd_ptr    <= rd_ptr + PW'(1);
            remaining <= remaining - RW'(1);
            if (!is_write) begin
              rd_data  <= ad;
              rd_valid <= 1'b1;
            end
            if (last_phase) done <= 1'b1;
          end
        end
        S_TURN: wr_ptr <= '0;
        default: ;
      endcase
    end
  end

  // Buffer contents carry no reset value; only the pointers are reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && wr_we) wbuf[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_pci_initiator_ctrl.sv
// Bench for pci_initiator_ctrl: a behavioural PCI target plus a transaction-level
// model of the write buffer and read data, checked with immediate assertions.
module tb_pci_initiator_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_n, gnt_n, frame_n, irdy_n, trdy_n, devsel_n;
  wire  [31:0] ad;
  logic [3:0]  c_be, cmd;
  logic        start, wr_we, rd_valid, busy, done, abort;
  logic [31:0] addr, wr_data, rd_data;
  logic [2:0]  len, fsm_state;

  logic [31:0] tgt_ad;
  logic        tgt_oe;
  assign ad = tgt_oe ? tgt_ad : 32'hzzzz_zzzz;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mbuf[8];
  int          mptr;

  always #5 clk = ~clk;

  pci_initiator_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_n(req_n), .gnt_n(gnt_n),
    .frame_n(frame_n), .irdy_n(irdy_n), .trdy_n(trdy_n), .devsel_n(devsel_n),
    .ad(ad), .c_be(c_be), .start(start), .cmd(cmd), .addr(addr), .len(len),
    .wr_we(wr_we), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .abort(abort), .fsm_state(fsm_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_n"}, req_n, 1);
    chk({tag, "_frame_n"}, frame_n, 1);
    chk({tag, "_irdy_n"}, irdy_n, 1);
    chk({tag, "_c_be"}, c_be, 4'b1111);
    chk({tag, "_ad"}, ad, 32'hzzzz_zzzz);
    chk({tag, "_rd_data"}, rd_data, 0);
    chk({tag, "_rd_valid"}, rd_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_abort"}, abort, 0);
  endtask

  task automatic chk_rd(input bit ev);
    logic [31:0] e;
    chk("rd_valid", rd_valid, ev);
    if (ev) begin
      e = exp_q.pop_front();
      chk("rd_data", rd_data, e);
    end
  endtask

  task automatic push(input logic [31:0] w);
    wr_we = 1'b1;
    wr_data = w;
    tick();
    wr_we = 1'b0;
    mbuf[mptr] = w;
    mptr = (mptr + 1) % 8;
  endtask

  // dlat: first DATA cycle in which the target claims (1..4), 5 = never claims.
  task automatic run_txn(input logic [3:0] c, input logic [31:0] a, input int l,
                         input int gdly, input int dlat, input int wmax,
                         input int slow_phase, input int rst_phase, input bit start_mid,
                         input bit rd_fixed, input logic [31:0] rd_word);
    int waits[8];
    int k, cyc, wcnt;
    bit fin, ab, ev, did_rst, complete, tmo;
    logic [31:0] drv;
    for (int i = 0; i < 8; i++) waits[i] = int'($urandom_range(0, wmax));
    if (slow_phase >= 0) waits[slow_phase] = 2;
    k = 0; cyc = 1; wcnt = 0; fin = 0; ab = 0; ev = 0; did_rst = 0;

    cmd = c; addr = a; len = 3'(l); start = 1'b1; gnt_n = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_req_n", req_n, 0);
    chk("req_ad_z", ad, 32'hzzzz_zzzz);
    repeat (gdly) begin
      tick();
      chk("req_hold", req_n, 0);
    end
    gnt_n = 1'b0;
    tick();
    chk("addr_frame_n", frame_n, 0);
    chk("addr_irdy_n", irdy_n, 1);
    chk("addr_req_n", req_n, 1);
    chk("addr_ad", ad, a);
    chk("addr_c_be", c_be, c);
    gnt_n = 1'($urandom_range(0, 1));
    devsel_n = 1'b1; trdy_n = 1'b1;
    tick();

    while (!fin && cyc < 64) begin
      if (k == rst_phase) begin
        tgt_oe = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        did_rst = 1; fin = 1;
      end else begin
        chk("data_irdy_n", irdy_n, 0);
        chk("data_c_be", c_be, 4'b0000);
        chk("data_frame_n", frame_n, (l + 1 - k) == 1);
        chk("data_busy", busy, 1);
        chk_rd(ev);
        if (c[0]) begin
          chk("data_wr_ad", ad, mbuf[k]);
        end else begin
          tgt_oe = 1'b0;
          #1;
          chk("data_rd_ad_z", ad, 32'hzzzz_zzzz);
        end
        if (start_mid && cyc == 1) begin
          start = 1'b1; addr = $urandom();
        end
        devsel_n = (cyc >= dlat) ? 1'b0 : 1'b1;
        trdy_n = 1'b1;
        if (!devsel_n) begin
          if (wcnt < waits[k]) wcnt++;
          else trdy_n = 1'b0;
        end
        drv = rd_fixed ? rd_word : $urandom();
        if (!c[0]) begin
          tgt_ad = drv;
          tgt_oe = !devsel_n;
        end
        complete = !devsel_n && !trdy_n;
        tmo = (dlat > 4) && (cyc == 4);
        tick();
        start = 1'b0;
        ev = 0;
        if (complete) begin
          if (!c[0]) begin
            exp_q.push_back(drv);
            ev = 1;
          end
          k++;
          wcnt = 0;
          if (k == l + 1) fin = 1;
        end
        if (tmo) begin
          ab = 1; fin = 1;
        end
        cyc++;
      end
    end

    tgt_oe = 1'b0; devsel_n = 1'b1; trdy_n = 1'b1; start = 1'b0; gnt_n = 1'b1;
    if (did_rst) begin
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_busy", busy, 0);
      mptr = 0;
      exp_q.delete();
    end else begin
      chk("data_bound", fin, 1);
      #1;
      chk("turn_frame_n", frame_n, 1);
      chk("turn_irdy_n", irdy_n, 1);
      chk("turn_c_be", c_be, 4'b1111);
      chk("turn_ad_z", ad, 32'hzzzz_zzzz);
      chk("turn_busy", busy, 1);
      chk("turn_done", done, !ab);
      chk("turn_abort", abort, ab);
      chk_rd(ev);
      tick();
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_abort", abort, 0);
      chk("idle_rd_valid", rd_valid, 0);
      mptr = 0;
      if (start_mid) begin
        tick();
        chk("ignored_start_req_n", req_n, 1);
        chk("ignored_start_busy", busy, 0);
      end
    end
  endtask

  initial begin
    logic        wbit;
    int          l, n, dl;
    rst_n = 1'b0; gnt_n = 1'b1; trdy_n = 1'b1; devsel_n = 1'b1;
    start = 1'b0; cmd = '0; addr = '0; len = '0; wr_we = 1'b0; wr_data = '0;
    tgt_ad = '0; tgt_oe = 1'b0;
    for (int i = 0; i < 8; i++) mbuf[i] = '0;
    mptr = 0;
    repeat (2) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // single zero-wait write
    push(32'h1234_5678);
    run_txn(4'b0111, 32'h0000_0001, 0, 0, 1, 0, -1, -1, 0, 0, 0);

    // burst write of four, phase 2 held by two wait states
    for (int i = 0; i < 4; i++) push($urandom());
    run_txn(4'b0111, 32'h0000_1000, 3, 0, 1, 0, 1, -1, 0, 0, 0);

    // burst read of two fixed words
    run_txn(4'b0110, 32'h0000_2000, 1, 0, 1, 0, -1, -1, 0, 1, 32'hAAAA_AAAA);

    // master abort on write and on read
    push($urandom());
    run_txn(4'b0111, 32'h0000_3000, 0, 1, 5, 0, -1, -1, 0, 0, 0);
    run_txn(4'b0110, 32'h0000_3004, 2, 0, 5, 0, -1, -1, 0, 0, 0);

    // reset during phase 2 of 4, then a normal transaction
    for (int i = 0; i < 4; i++) push($urandom());
    run_txn(4'b0111, 32'h0000_4000, 3, 0, 1, 0, -1, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) push($urandom());
    run_txn(4'b0111, 32'h0000_4100, 1, 0, 1, 0, -1, -1, 0, 0, 0);

    // start pulsed during DATA must be ignored
    run_txn(4'b0110, 32'h0000_5000, 2, 0, 2, 1, -1, -1, 1, 0, 0);

    // nine pushes wrap and overwrite entry 0, then an 8-phase write
    for (int i = 0; i < 9; i++) push($urandom());
    run_txn(4'b0111, 32'h0000_6000, 7, 2, 3, 1, -1, -1, 0, 0, 0);

    // randomized transactions
    for (int t = 0; t < 24; t++) begin
      wbit = 1'($urandom_range(0, 1));
      l = int'($urandom_range(0, 7));
      if (wbit) begin
        n = l + 1 + int'($urandom_range(0, 2));
        for (int i = 0; i < n; i++) push($urandom());
      end
      dl = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(1, 4));
      run_txn({3'($urandom_range(0, 7)), wbit}, $urandom(), l,
              int'($urandom_range(0, 3)), dl, 2, -1, -1, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pci_initiator_ctrl.md
# pci_initiator_ctrl

PCI bus initiator (master) for the 32-bit multiplexed AD bus; the requesting counterpart of the team's target controller. Accepts a transaction request from local logic, arbitrates with REQ#/GNT#, drives the address phase and 1–8 data phases of a burst read or write, and reports completion or master abort. Sole initiator on the bus: FRAME#/IRDY# are driven continuously; AD is driven only during the address phase and write data phases.

## Interface
- MAX_BURST, 8: write-buffer depth and maximum data phases per transaction.
- DEVSEL_TIMEOUT, 4: clocks after the address phase within which DEVSEL# must be sampled low.
- clk  in  1  bus clock; all sampling on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_n  out  1  bus request, active low.
- gnt_n  in  1  bus grant, active low.
- frame_n  out  1  FRAME#, active low.
- irdy_n  out  1  IRDY#, active low.
- trdy_n  in  1  TRDY# from target.
- devsel_n  in  1  DEVSEL# from target.
- ad  inout  32  multiplexed address/data.
- c_be  out  4  command in address phase, byte enables (4'b0000) in data phases, 4'b1111 otherwise.
- start  in  1  one-cycle transaction request; honoured only when busy=0.
- cmd  in  4  PCI command; bit 0 = 1 write, 0 read; latched on start.
- addr  in  32  start address; latched on start.
- len  in  3  data phases minus one (0..7); latched on start.
- wr_we  in  1  push wr_data into write buffer (IDLE only).
- wr_data  in  32  write word.
- rd_data  out  32  read word.
- rd_valid  out  1  one-cycle strobe per completed read data phase.
- busy  out  1  high from accepted start through TURN.
- done  out  1  one-cycle pulse on normal completion.
- abort  out  1  one-cycle pulse on master abort.

## Operation
- States: IDLE, REQ, ADDR, DATA, TURN.
- IDLE: wr_we writes buf[wr_ptr], wr_ptr++ (wraps at MAX_BURST; pushes past 8 overwrite entry 0). start latches cmd/addr/len, remaining=len+1, rd_ptr=0, go REQ.
- REQ: req_n=0. On sampled gnt_n=0 go ADDR.
- ADDR (one cycle): frame_n=0, ad=addr, c_be=cmd, req_n=1. Clear devsel counter. Next: DATA.
- DATA: irdy_n=0, c_be=0000. Write: ad=buf[rd_ptr]. Read: ad released (z) throughout.
- Phase completes on edge where irdy_n=0, trdy_n=0, devsel_n=0: rd_ptr++, remaining--; read captures ad into rd_data, rd_valid=1 next cycle.
- frame_n=1 while remaining==1 (final phase, IRDY# still low). Completion of final phase -> TURN, done pulse.
- Master abort: devsel_n not sampled low by DEVSEL_TIMEOUT-th edge after ADDR -> frame_n=1, irdy_n=1, go TURN, abort pulse; no rd_valid.
- TURN (one cycle): frame_n=1, irdy_n=1, ad z, c_be=1111; clear wr_ptr; go IDLE, busy=0.
- start while busy ignored; wr_we outside IDLE ignored. No STOP#/retry/disconnect support; no latency timer.

## Timing
- Reset values: req_n=1, frame_n=1, irdy_n=1, ad=z, c_be=1111, rd_data=0, rd_valid=0, busy=0, done=0, abort=0; state IDLE, pointers 0.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous); buffer contents undefined.
- start at edge N: busy=1 and req_n=0 after N. gnt_n sampled low at edge G: ADDR cycle after G.
- Zero-wait target: 1-phase transaction = ADDR + 1 DATA + TURN; done asserted during TURN.
- Each TRDY#-high cycle with IRDY# low inserts one wait state; data and frame_n held stable.
- gnt_n deassertion after ADDR does not affect the transaction.

## Test plan
- Single write: push 0x12345678, start cmd=0111 addr=1 len=0, gnt at once, target zero-wait -> ADDR ad=0x00000001 c_be=0111, one DATA ad=0x12345678 with frame_n=1, done 1 cycle later.
- Burst write len=3 with TRDY# high for 2 cycles on phase 2 -> four words in push order, phase 2 held 3 cycles, frame_n rises only on phase 4.
- Burst read cmd=0110 len=1, target returns 0xAAAAAAAA twice -> two rd_valid strobes with rd_data=0xAAAAAAAA, ad z in DATA, done.
- Master abort: devsel_n held high -> frame_n/irdy_n high after 4th edge past ADDR, abort pulse, no done, busy low next cycle.
- Reset mid-burst at phase 2 of 4 -> all outputs at reset values same cycle; new start after release runs normally.
- start pulsed during DATA -> ignored; only one ADDR phase observed.
